// File: rtl/otter_branch_predictor.sv
// ============================================================================
// Module   : otter_branch_predictor
// Brief    : Direct-mapped branch target buffer with saturating direction
//            counters, EX-stage mispredict detection and resolution statistics.
// Revision : 1.0
// ============================================================================
`default_nettype none

module otter_branch_predictor #(
  parameter int ENTRIES  = 64,
  parameter int CTR_BITS = 2,
  parameter int TAG_BITS = 8
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        BP_EN,
  input  logic        CLEAR,
  input  logic [31:0] IF_PC,
  output logic        PRED_HIT,
  output logic        PRED_TAKEN,
  output logic [31:0] PRED_TARGET,
  input  logic        EX_VALID,
  input  logic        EX_IS_JUMP,
  input  logic [31:0] EX_PC,
  input  logic        EX_TAKEN,
  input  logic [31:0] EX_TARGET,
  input  logic        EX_PRED_TAKEN,
  input  logic [31:0] EX_PRED_TARGET,
  output logic        MISPREDICT,
  output logic [31:0] CORRECT_PC,
  output logic [15:0] BR_COUNT,
  output logic [15:0] MISP_COUNT
);

  localparam int IDX = $clog2(ENTRIES);

  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_ZERO = '0;
  // Weakly-taken allocation value: only the MSB set.
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_MAX ^ (CTR_MAX >> 1);
  localparam logic [CTR_BITS-1:0] CTR_ONE  = ~(CTR_MAX << 1);

  // Table storage
  logic                valid_q [ENTRIES];
  logic [TAG_BITS-1:0] tag_q   [ENTRIES];
  logic [31:0]         tgt_q   [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q   [ENTRIES];

  logic [15:0] br_count_q, br_count_d;
  logic [15:0] misp_count_q, misp_count_d;

  logic [IDX-1:0]      if_idx, ex_idx;
  logic [TAG_BITS-1:0] if_tag, ex_tag;
  logic [31:0]         if_pc_plus4, ex_pc_plus4;

  logic                ex_hit;
  logic [CTR_BITS-1:0] ex_ctr;
  logic                wr_en;
  logic [31:0]         wr_tgt_d;
  logic [CTR_BITS-1:0] wr_ctr_d;

  assign if_idx      = IF_PC[IDX+1:2];
  assign if_tag      = IF_PC[IDX+1+TAG_BITS:IDX+2];
  assign ex_idx      = EX_PC[IDX+1:2];
  assign ex_tag      = EX_PC[IDX+1+TAG_BITS:IDX+2];
  assign if_pc_plus4 = IF_PC + 32'd4;
  assign ex_pc_plus4 = EX_PC + 32'd4;

  // Fetch-side lookup reads the registered table only, so a same-cycle update
  // is not visible until the following cycle.
  assign PRED_HIT    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign PRED_TAKEN  = BP_EN && PRED_HIT && ctr_q[if_idx][CTR_BITS-1];
  assign PRED_TARGET = PRED_TAKEN ? tgt_q[if_idx] : if_pc_plus4;

  assign MISPREDICT  = EX_VALID &&
                       ((EX_TAKEN != EX_PRED_TAKEN) ||
                        (EX_TAKEN && (EX_TARGET != EX_PRED_TARGET)));
  assign CORRECT_PC  = EX_TAKEN ? EX_TARGET : ex_pc_plus4;

  assign BR_COUNT    = br_count_q;
  assign MISP_COUNT  = misp_count_q;

  // Resolution-side entry update
  always_comb begin
    ex_hit   = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    ex_ctr   = ctr_q[ex_idx];
    wr_en    = 1'b0;
    wr_tgt_d = tgt_q[ex_idx];
    wr_ctr_d = ex_ctr;
    if (EX_VALID) begin
      if (EX_IS_JUMP) begin
        wr_en    = 1'b1;
        wr_tgt_d = EX_TARGET;
        wr_ctr_d = CTR_MAX;
      end else if (ex_hit) begin
        wr_en = 1'b1;
        if (EX_TAKEN) begin
          wr_tgt_d = EX_TARGET;
          if (ex_ctr != CTR_MAX) wr_ctr_d = ex_ctr + CTR_ONE;
        end else if (ex_ctr != CTR_ZERO) begin
          wr_ctr_d = ex_ctr - CTR_ONE;
        end
      end else if (EX_TAKEN) begin
        // Miss on a taken branch replaces whatever aliased into this slot.
        wr_en    = 1'b1;
        wr_tgt_d = EX_TARGET;
        wr_ctr_d = CTR_INIT;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= '0;
      end
    end else if (CLEAR) begin
      // fence.i invalidate wins over any concurrent training write.
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= '0;
      end
    end else if (wr_en) begin
      valid_q[ex_idx] <= 1'b1;
      tag_q[ex_idx]   <= ex_tag;
      tgt_q[ex_idx]   <= wr_tgt_d;
      ctr_q[ex_idx]   <= wr_ctr_d;
    end
  end

  // Saturating statistics, unaffected by CLEAR
  always_comb begin
    br_count_d   = br_count_q;
    misp_count_d = misp_count_q;
    if (EX_VALID && (br_count_q != 16'hFFFF)) br_count_d = br_count_q + 16'd1;
    if (MISPREDICT && (misp_count_q != 16'hFFFF)) misp_count_d = misp_count_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      br_count_q   <= '0;
      misp_count_q <= '0;
    end else begin
      br_count_q   <= br_count_d;
      misp_count_q <= misp_count_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_otter_branch_predictor.sv
// ============================================================================
// Module   : tb_otter_branch_predictor
// Brief    : Scoreboard bench for otter_branch_predictor (64 x 2-bit x 8-tag).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_otter_branch_predictor;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        BP_EN;
  logic        CLEAR;
  logic [31:0] IF_PC;
  logic        PRED_HIT;
  logic        PRED_TAKEN;
  logic [31:0] PRED_TARGET;
  logic        EX_VALID;
  logic        EX_IS_JUMP;
  logic [31:0] EX_PC;
  logic        EX_TAKEN;
  logic [31:0] EX_TARGET;
  logic        EX_PRED_TAKEN;
  logic [31:0] EX_PRED_TARGET;
  logic        MISPREDICT;
  logic [31:0] CORRECT_PC;
  logic [15:0] BR_COUNT;
  logic [15:0] MISP_COUNT;

  otter_branch_predictor #(
    .ENTRIES (64),
    .CTR_BITS(2),
    .TAG_BITS(8)
  ) dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .BP_EN         (BP_EN),
    .CLEAR         (CLEAR),
    .IF_PC         (IF_PC),
    .PRED_HIT      (PRED_HIT),
    .PRED_TAKEN    (PRED_TAKEN),
    .PRED_TARGET   (PRED_TARGET),
    .EX_VALID      (EX_VALID),
    .EX_IS_JUMP    (EX_IS_JUMP),
    .EX_PC         (EX_PC),
    .EX_TAKEN      (EX_TAKEN),
    .EX_TARGET     (EX_TARGET),
    .EX_PRED_TAKEN (EX_PRED_TAKEN),
    .EX_PRED_TARGET(EX_PRED_TARGET),
    .MISPREDICT    (MISPREDICT),
    .CORRECT_PC    (CORRECT_PC),
    .BR_COUNT      (BR_COUNT),
    .MISP_COUNT    (MISP_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef enum int {S_HIT, S_TAKEN, S_TGT, S_MISP, S_CPC, S_BR, S_MC} sig_e;
  typedef struct {
    string       tag;
    sig_e        sig;
    logic [31:0] exp;
  } sb_t;

  sb_t         sb_q[$];
  int          n_vec  = 0;
  int          n_bad  = 0;
  logic [15:0] exp_br = 16'd0;
  logic [15:0] exp_mc = 16'd0;
  logic        cur_misp = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input sig_e s, input logic [31:0] e);
    sb_t item;
    item.tag = tag;
    item.sig = s;
    item.exp = e;
    sb_q.push_back(item);
  endtask

  // Compare every queued expectation against the settled DUT outputs.
  task automatic drain();
    sb_t         item;
    logic [31:0] obs;
    #1;
    while (sb_q.size() > 0) begin
      item = sb_q.pop_front();
      case (item.sig)
        S_HIT:   obs = {31'd0, PRED_HIT};
        S_TAKEN: obs = {31'd0, PRED_TAKEN};
        S_TGT:   obs = PRED_TARGET;
        S_MISP:  obs = {31'd0, MISPREDICT};
        S_CPC:   obs = CORRECT_PC;
        S_BR:    obs = {16'd0, BR_COUNT};
        default: obs = {16'd0, MISP_COUNT};
      endcase
      check(item.tag, obs, item.exp);
    end
  endtask

  task automatic exp_lookup(input string tag, input logic [31:0] pc, input logic hit,
                            input logic tkn, input logic [31:0] tgt);
    IF_PC = pc;
    push({tag, ".hit"},   S_HIT,   {31'd0, hit});
    push({tag, ".taken"}, S_TAKEN, {31'd0, tkn});
    push({tag, ".tgt"},   S_TGT,   tgt);
    push({tag, ".br"},    S_BR,    {16'd0, exp_br});
    push({tag, ".misp#"}, S_MC,    {16'd0, exp_mc});
  endtask

  task automatic set_ex(input string tag, input logic jmp, input logic [31:0] pc,
                        input logic tkn, input logic [31:0] tgt,
                        input logic ptkn, input logic [31:0] ptgt);
    logic m;
    EX_VALID       = 1'b1;
    EX_IS_JUMP     = jmp;
    EX_PC          = pc;
    EX_TAKEN       = tkn;
    EX_TARGET      = tgt;
    EX_PRED_TAKEN  = ptkn;
    EX_PRED_TARGET = ptgt;
    m = (tkn != ptkn) || (tkn && (tgt != ptgt));
    cur_misp = m;
    push({tag, ".mispredict"}, S_MISP, {31'd0, m});
    if (m) push({tag, ".correct_pc"}, S_CPC, tkn ? tgt : pc + 32'd4);
  endtask

  task automatic tick();
    drain();
    @(posedge CLK);
    if (RESET_N) begin
      if (EX_VALID && exp_br != 16'hFFFF) exp_br = exp_br + 16'd1;
      if (cur_misp && exp_mc != 16'hFFFF) exp_mc = exp_mc + 16'd1;
    end
    @(negedge CLK);
    EX_VALID   = 1'b0;
    EX_IS_JUMP = 1'b0;
    CLEAR      = 1'b0;
    cur_misp   = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  mctr;
    logic        p;
    logic [31:0] ptgt;
    logic        dirs[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    RESET_N = 1'b0; BP_EN = 1'b1; CLEAR = 1'b0; IF_PC = '0;
    EX_VALID = 1'b0; EX_IS_JUMP = 1'b0; EX_PC = '0; EX_TAKEN = 1'b0;
    EX_TARGET = '0; EX_PRED_TAKEN = 1'b0; EX_PRED_TARGET = '0;
    @(negedge CLK);

    // Held in reset: outputs idle, MISPREDICT live, no training, no counting
    exp_lookup("in_reset", 32'h100, 1'b0, 1'b0, 32'h104);
    set_ex("in_reset", 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    tick();
    RESET_N = 1'b1;
    exp_lookup("after_reset", 32'h100, 1'b0, 1'b0, 32'h104);
    tick();

    // Allocation on a taken miss; same-cycle lookup sees pre-update state
    exp_lookup("alloc_same_cyc", 32'h100, 1'b0, 1'b0, 32'h104);
    set_ex("alloc", 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    tick();

    // Counter walk: 2 -> 1,0,0 -> 1,2,3,3 -> 2,1
    mctr = 2'd2;
    for (int i = 0; i < 9; i++) begin
      p    = mctr[1];
      ptgt = p ? 32'h80 : 32'h104;
      exp_lookup($sformatf("walk%0d", i), 32'h100, 1'b1, p, ptgt);
      set_ex($sformatf("walk%0d", i), 1'b0, 32'h100, dirs[i], 32'h80, p, ptgt);
      if (dirs[i]) mctr = (mctr == 2'd3) ? 2'd3 : mctr + 2'd1;
      else         mctr = (mctr == 2'd0) ? 2'd0 : mctr - 2'd1;
      tick();
    end
    exp_lookup("walk_end", 32'h100, 1'b1, 1'b0, 32'h104);
    tick();

    // Aliasing at index 0
    exp_lookup("alias_miss", 32'h200, 1'b0, 1'b0, 32'h204);
    set_ex("alias_alloc", 1'b0, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
    tick();
    exp_lookup("alias_new", 32'h200, 1'b1, 1'b1, 32'h300);
    tick();
    exp_lookup("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
    tick();

    // Jump writes a strongly-taken entry; wrong target counts as mispredict
    exp_lookup("jmp_pre", 32'h104, 1'b0, 1'b0, 32'h108);
    set_ex("jmp", 1'b1, 32'h104, 1'b1, 32'h400, 1'b1, 32'h500);
    tick();
    exp_lookup("jmp_hit", 32'h104, 1'b1, 1'b1, 32'h400);
    set_ex("jmp_nt", 1'b0, 32'h104, 1'b0, 32'h400, 1'b1, 32'h400);
    tick();
    exp_lookup("jmp_ctr2", 32'h104, 1'b1, 1'b1, 32'h400);
    set_ex("jmp_ok", 1'b0, 32'h104, 1'b1, 32'h400, 1'b1, 32'h400);
    tick();

    // Not-taken miss leaves the table untouched
    set_ex("nt_miss", 1'b0, 32'h108, 1'b0, 32'h999, 1'b0, 32'h10C);
    tick();
    exp_lookup("nt_miss_chk", 32'h108, 1'b0, 1'b0, 32'h10C);
    tick();

    // CLEAR beats a concurrent allocation and wipes existing entries
    CLEAR = 1'b1;
    set_ex("clear_upd", 1'b0, 32'h10C, 1'b1, 32'h600, 1'b0, 32'h110);
    tick();
    exp_lookup("clear_new", 32'h10C, 1'b0, 1'b0, 32'h110);
    tick();
    exp_lookup("clear_old0", 32'h200, 1'b0, 1'b0, 32'h204);
    tick();
    exp_lookup("clear_old1", 32'h104, 1'b0, 1'b0, 32'h108);
    tick();

    // Disabled predictor still trains
    BP_EN = 1'b0;
    set_ex("bpen0_upd", 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    tick();
    exp_lookup("bpen0", 32'h100, 1'b1, 1'b0, 32'h104);
    tick();
    BP_EN = 1'b1;
    exp_lookup("bpen1", 32'h100, 1'b1, 1'b1, 32'h80);
    tick();

    // PC+4 wraps to zero
    exp_lookup("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
    set_ex("wrap", 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h40);
    tick();

    // Reset asserted while an update is pending discards it
    set_ex("rst_mid", 1'b0, 32'h110, 1'b1, 32'h700, 1'b0, 32'h114);
    RESET_N = 1'b0;
    exp_br = 16'd0;
    exp_mc = 16'd0;
    tick();
    RESET_N = 1'b1;
    exp_lookup("rst_mid_new", 32'h110, 1'b0, 1'b0, 32'h114);
    tick();
    exp_lookup("rst_mid_old", 32'h100, 1'b0, 1'b0, 32'h104);
    tick();

    // Statistic saturation
    for (int i = 0; i < 65540; i++) begin
      EX_VALID = 1'b1; EX_IS_JUMP = 1'b0; EX_PC = 32'h120; EX_TAKEN = 1'b1;
      EX_TARGET = 32'h40; EX_PRED_TAKEN = 1'b0; EX_PRED_TARGET = 32'h124;
      cur_misp = 1'b1;
      tick();
    end
    exp_lookup("saturate", 32'h300, 1'b0, 1'b0, 32'h304);
    push("saturate.br_abs", S_BR, 32'h0000_FFFF);
    push("saturate.mc_abs", S_MC, 32'h0000_FFFF);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/otter_branch_predictor.md
OTTER_BRANCH_PREDICTOR -- requirements
Module: otter_branch_predictor

Interface
REQ-001 The block SHALL have parameter ENTRIES, default 64, meaning the number of table entries (power of 2, 4..1024).
REQ-002 The block SHALL have parameter CTR_BITS, default 2, meaning the saturating-counter width (1..4).
REQ-003 The block SHALL have parameter TAG_BITS, default 8, meaning the stored PC tag width (1..16).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset; all ports are listed below.
- CLK  in  1  clock; all state changes on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- BP_EN  in  1  predictor enable; 0 forces a not-taken prediction.
- CLEAR  in  1  synchronous invalidate-all, used on fence.i.
- IF_PC  in  32  fetch PC to predict.
- PRED_HIT  out  1  valid entry with a matching tag.
- PRED_TAKEN  out  1  predicted taken.
- PRED_TARGET  out  32  predicted next PC.
- EX_VALID  in  1  resolved control-flow instruction in EX this cycle.
- EX_IS_JUMP  in  1  1 = JAL/JALR, 0 = conditional branch.
- EX_PC  in  32  PC of the resolved instruction.
- EX_TAKEN  in  1  actual direction.
- EX_TARGET  in  32  actual taken target.
- EX_PRED_TAKEN  in  1  prediction made for it, piped from IF.
- EX_PRED_TARGET  in  32  predicted target, piped from IF.
- MISPREDICT  out  1  redirect and flush request.
- CORRECT_PC  out  32  redirect PC.
- BR_COUNT  out  16  resolved-instruction count.
- MISP_COUNT  out  16  mispredict count.

Function
REQ-005 Index SHALL be IF_PC[IDX+1:2] with IDX=log2(ENTRIES), and tag SHALL be IF_PC[IDX+1+TAG_BITS:IDX+2]; EX_PC SHALL be split the same way.
REQ-006 Each entry SHALL hold a valid bit, a tag, a 32-bit target and a CTR_BITS counter, all in flops.
REQ-007 Lookup SHALL be combinational, with zero latency from IF_PC. PRED_HIT = valid & tag match.
REQ-008 PRED_TAKEN SHALL be BP_EN & PRED_HIT & counter MSB.
REQ-009 PRED_TARGET SHALL be the entry target when PRED_TAKEN=1, else IF_PC+4 (mod 2^32).
REQ-010 MISPREDICT SHALL be combinational: EX_VALID & ((EX_TAKEN != EX_PRED_TAKEN) | (EX_TAKEN & EX_TARGET != EX_PRED_TARGET)).
REQ-011 CORRECT_PC SHALL be EX_TARGET if EX_TAKEN, else EX_PC+4. It is valid only while MISPREDICT=1.
REQ-012 Updates SHALL occur on the clock edge when EX_VALID=1, independent of BP_EN.
- Update on a hit, conditional branch: counter +1 if taken, -1 if not taken, saturating at 0 and 2^CTR_BITS-1; target is overwritten if taken.
- Update on a miss, taken branch: allocate (valid=1, tag, target, counter = 2^(CTR_BITS-1)), replacing any aliased entry.
- Update on a miss, not-taken branch: no table change.
- Update on a jump, hit or miss: write valid, tag, target, and counter = 2^CTR_BITS-1.
REQ-013 When a lookup and an update hit the same index in one cycle, the prediction SHALL use the pre-update contents (no bypass).
REQ-014 CLEAR=1 SHALL clear all valid bits and counters on the edge, and SHALL take priority over a simultaneous update; the statistics counters SHALL be unaffected by CLEAR.
REQ-015 BR_COUNT SHALL increment on each EX_VALID edge, and MISP_COUNT SHALL increment on each edge with MISPREDICT=1; both SHALL saturate at 0xFFFF.
REQ-016 Targets wider than 32 bits and carry out of PC+4 SHALL be truncated to 32 bits.

Reset
REQ-017 RESET_N=0 SHALL immediately clear all valid bits, counters, targets, tags, BR_COUNT and MISP_COUNT, independent of CLK.
REQ-018 During reset and after it, with no updates: PRED_HIT=0, PRED_TAKEN=0, PRED_TARGET=IF_PC+4.
REQ-019 During reset, MISPREDICT SHALL still follow REQ-010, and the counters SHALL remain 0 until RESET_N=1.
REQ-020 Reset asserted mid-update SHALL discard the update.

Verification (ENTRIES=64, CTR_BITS=2, TAG_BITS=8)
REQ-021 Reset then IF_PC=0x100 -> PRED_HIT=0, PRED_TAKEN=0, PRED_TARGET=0x104, BR_COUNT=MISP_COUNT=0.
REQ-022 Taken-branch update EX_PC=0x100, EX_TARGET=0x80, EX_PRED_TAKEN=0 -> MISPREDICT=1 and CORRECT_PC=0x80 that cycle; next cycle IF_PC=0x100 -> HIT=1, TAKEN=1, TARGET=0x80; MISP_COUNT=1.
REQ-023 Counter walk from that entry:
- Not-taken updates ×3 -> counter 1, 0, 0; TAKEN=0 from the first one.
- Taken updates ×4 -> counter 1, 2, 3, 3.
REQ-024 Aliasing: 0x100 allocated, then IF_PC=0x200 (same index 0, tag 0x02 vs 0x01) -> HIT=0. A taken update at 0x200 makes 0x200 hit and 0x100 miss.
REQ-025 Same-cycle checks:
- Lookup and update at 0x100 -> pre-update prediction is returned.
- CLEAR together with an update -> entry invalid next cycle.
- BP_EN=0 -> TAKEN=0 while the table still trains.
REQ-026 Drive 65,540 EX_VALID cycles with mispredicts -> BR_COUNT and MISP_COUNT hold at 0xFFFF.
